// File: rtl/isa_pkg.sv
// Shared ISA constants, fetch/decode state encoding and the decode-facing payload.
package isa_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned PC_W   = 32;

  localparam logic [2:0]        IMM_PREFIX = 3'b110;
  localparam logic [WORD_W-1:0] INT_OPCODE = 16'hE000;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] imm;
    logic              has_imm;
    logic [PC_W-1:0]   pc;
    logic              is_int;
  } dec_out_t;

  // Opcode words carrying this prefix are followed by one immediate word.
  function automatic logic is_prefix(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3] == IMM_PREFIX;
  endfunction

endpackage

// File: rtl/int_pending_reg.sv
// Interrupt request edge detector with a sticky pending flag.
// Only instantiated when INTERRUPT_EN is defined.
module int_pending_reg (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_interrupt,
  input  logic i_inject,
  output logic o_pending
);

  logic irq_q;

  // A new rising edge wins over a same-cycle injection so no request is lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_q     <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      irq_q <= i_interrupt;
      if (i_interrupt && !irq_q) begin
        o_pending <= 1'b1;
      end else if (i_inject) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode register: pairs prefix opcodes with their immediate, backpressures
// fetch on decode stall, drops in-flight words on flush. INTERRUPT_EN adds interrupt injection.
module fetch_decode_buffer
  import isa_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WORD_W-1:0] i_word,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_interrupt,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_imm,
  output logic              o_has_imm,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_is_int
);

  fetch_state_e      state_q;
  logic [WORD_W-1:0] hold_word_q;
  logic [PC_W-1:0]   hold_pc_q;
  logic              valid_q;
  dec_out_t          out_q;

  logic out_free;
  logic inject;
  logic accept;

  assign out_free = !(valid_q && i_stall);

`ifdef INTERRUPT_EN
  logic pending;

  int_pending_reg u_int_pending_reg (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_interrupt (i_interrupt),
    .i_inject    (inject),
    .o_pending   (pending)
  );

  // Injection waits for an instruction boundary; a flush cycle defers it so it is not dropped.
  assign inject = pending && (state_q == FIRST) && out_free && !i_flush;
`else
  logic unused_interrupt;

  assign unused_interrupt = i_interrupt;
  assign inject           = 1'b0;
`endif

  assign o_ready = out_free && !inject;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= FIRST;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      valid_q     <= 1'b0;
      out_q       <= '0;
    end else if (i_flush) begin
      state_q      <= FIRST;
      hold_word_q  <= '0;
      hold_pc_q    <= '0;
      valid_q      <= 1'b0;
      out_q.is_int <= 1'b0;
    end else if (out_free) begin
      if (inject) begin
        valid_q       <= 1'b1;
        out_q.instr   <= INT_OPCODE;
        out_q.imm     <= '0;
        out_q.has_imm <= 1'b0;
        out_q.pc      <= i_pc;
        out_q.is_int  <= 1'b1;
      end else if (accept && (state_q == FIRST) && !is_prefix(i_word)) begin
        valid_q       <= 1'b1;
        out_q.instr   <= i_word;
        out_q.imm     <= '0;
        out_q.has_imm <= 1'b0;
        out_q.pc      <= i_pc;
        out_q.is_int  <= 1'b0;
      end else if (accept && (state_q == SECOND)) begin
        valid_q       <= 1'b1;
        out_q.instr   <= hold_word_q;
        out_q.imm     <= i_word;
        out_q.has_imm <= 1'b1;
        out_q.pc      <= hold_pc_q;
        out_q.is_int  <= 1'b0;
        state_q       <= FIRST;
        hold_word_q   <= '0;
        hold_pc_q     <= '0;
      end else begin
        valid_q      <= 1'b0;
        out_q.is_int <= 1'b0;
      end

      // Opcode half of a pair parks in the hold register until its immediate arrives.
      if (accept && (state_q == FIRST) && is_prefix(i_word)) begin
        state_q     <= SECOND;
        hold_word_q <= i_word;
        hold_pc_q   <= i_pc;
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_instr   = out_q.instr;
  assign o_imm     = out_q.imm;
  assign o_has_imm = out_q.has_imm;
  assign o_pc      = out_q.pc;
  assign o_is_int  = out_q.is_int;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed plus randomized bench for fetch_decode_buffer against a queue-based instruction model.
module tb_fetch_decode_buffer;

  localparam logic [15:0] INT_OP = 16'hE000;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [15:0] i_word = '0;
  logic [31:0] i_pc = '0;
  logic        i_valid = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_interrupt = 1'b0;
  logic        o_ready, o_valid, o_has_imm, o_is_int;
  logic [15:0] o_instr, o_imm;
  logic [31:0] o_pc;

  fetch_decode_buffer dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_word      (i_word),
    .i_pc        (i_pc),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_interrupt (i_interrupt),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_imm       (o_imm),
    .o_has_imm   (o_has_imm),
    .o_pc        (o_pc),
    .o_is_int    (o_is_int)
  );

  always #5 i_clk = ~i_clk;

  int passes = 0;
  int checks = 0;

  // Reference model: the presented instruction plus the words of a partly fetched one.
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = '0;
  logic [15:0] m_imm = '0;
  logic        m_has = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_int = 1'b0;
  logic [15:0] part_w[$];
  logic [31:0] part_pc = '0;
  logic        m_pend = 1'b0;
  logic        m_prev_irq = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic emit(input logic [15:0] ins, input logic [15:0] imm, input logic has,
                      input logic [31:0] pc, input logic is_int);
    m_valid = 1'b1;
    m_instr = ins;
    m_imm   = imm;
    m_has   = has;
    m_pc    = pc;
    m_int   = is_int;
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check outputs after it.
  task automatic step(input logic v, input logic [15:0] w, input logic [31:0] pc,
                      input logic st, input logic fl, input logic rs, input logic irq);
    logic free, inj, exp_ready, acc, rise;
    i_valid = v; i_word = w; i_pc = pc; i_stall = st; i_flush = fl;
    i_reset = rs; i_interrupt = irq;
    #1;
    free = !(m_valid && st);
`ifdef INTERRUPT_EN
    inj  = m_pend && (part_w.size() == 0) && free && !fl;
    rise = irq && !m_prev_irq;
`else
    inj  = 1'b0;
    rise = 1'b0;
`endif
    exp_ready = free && !inj;
    acc = v && exp_ready;
    if (!rs) check("ready", 32'(o_ready), 32'(exp_ready));
    @(posedge i_clk);
    if (rs) begin
      m_valid = 0; m_instr = 0; m_imm = 0; m_has = 0; m_pc = 0; m_int = 0;
      part_w.delete();
      m_pend = 0; m_prev_irq = 0;
    end else begin
      if (fl) begin
        m_valid = 0; m_int = 0;
        part_w.delete();
      end else if (free) begin
        if (inj) emit(INT_OP, 16'h0, 1'b0, pc, 1'b1);
        else if (acc && part_w.size() == 1) begin
          emit(part_w[0], w, 1'b1, part_pc, 1'b0);
          part_w.delete();
        end else if (acc && w[15:13] == 3'b110) begin
          part_w.push_back(w);
          part_pc = pc;
          m_valid = 0; m_int = 0;
        end else if (acc) emit(w, 16'h0, 1'b0, pc, 1'b0);
        else begin
          m_valid = 0; m_int = 0;
        end
      end
      m_pend = (m_pend && !inj) || rise;
      m_prev_irq = irq;
    end
    #1;
    check("valid", 32'(o_valid), 32'(m_valid));
    check("is_int", 32'(o_is_int), 32'(m_int));
    if (m_valid) begin
      check("instr", 32'(o_instr), 32'(m_instr));
      check("imm", 32'(o_imm), 32'(m_imm));
      check("has_imm", 32'(o_has_imm), 32'(m_has));
      check("pc", o_pc, m_pc);
    end
    @(negedge i_clk);
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] pc;
    @(negedge i_clk);
    step(0, 16'h0, 0, 0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0, 1, 0);
    i_reset = 0;
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_instr", 32'(o_instr), 32'd0);
    check("rst_imm", 32'(o_imm), 32'd0);
    check("rst_has_imm", 32'(o_has_imm), 32'd0);
    check("rst_pc", o_pc, 32'd0);

    // Back-to-back single-word instructions.
    step(1, 16'h1234, 0, 0, 0, 0, 0);
    check("dir_instr0", 32'(o_instr), 32'h1234);
    step(1, 16'h2000, 1, 0, 0, 0, 0);
    check("dir_instr1", 32'(o_instr), 32'h2000);
    step(0, 16'h0, 2, 0, 0, 0, 0);

    // Two-word instruction.
    step(1, 16'hC005, 4, 0, 0, 0, 0);
    check("pair_gap", 32'(o_valid), 32'd0);
    step(1, 16'h00FF, 5, 0, 0, 0, 0);
    check("pair_instr", 32'(o_instr), 32'hC005);
    check("pair_imm", 32'(o_imm), 32'h00FF);
    check("pair_pc", o_pc, 32'd4);

    // Stall for three cycles while a word waits.
    step(1, 16'h3333, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h4444, 7, 1, 0, 0, 0);
      check("stall_hold", 32'(o_instr), 32'h3333);
    end
    step(1, 16'h4444, 7, 0, 0, 0, 0);
    check("after_stall", 32'(o_instr), 32'h4444);

    // Flush mid-pair discards the held opcode and the flush-cycle word.
    step(1, 16'hC005, 10, 0, 0, 0, 0);
    step(1, 16'h9999, 11, 0, 1, 0, 0);
    check("flush_valid", 32'(o_valid), 32'd0);
    step(1, 16'h1111, 20, 0, 0, 0, 0);
    check("post_flush", 32'(o_instr), 32'h1111);
    step(0, 16'h0, 21, 0, 0, 0, 0);

`ifdef INTERRUPT_EN
    // Interrupt raised mid-pair is injected after the pair completes.
    step(1, 16'hC005, 40, 0, 0, 0, 0);
    step(1, 16'h0001, 41, 0, 0, 0, 1);
    check("int_pair", 32'(o_instr), 32'hC005);
    step(1, 16'h7777, 42, 0, 0, 0, 0);
    check("int_op", 32'(o_instr), 32'(INT_OP));
    check("int_pc", o_pc, 32'd42);
    step(1, 16'h7777, 42, 0, 0, 0, 0);
    check("int_resume", 32'(o_instr), 32'h7777);
`endif

    // Reset while valid; a prefix word afterwards starts a new pair.
    step(1, 16'h5555, 25, 0, 0, 0, 0);
    step(1, 16'h6666, 26, 0, 0, 1, 0);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    step(1, 16'hC0AA, 30, 0, 0, 0, 0);
    step(1, 16'h0002, 31, 0, 0, 0, 0);
    check("rst_pair_instr", 32'(o_instr), 32'hC0AA);
    check("rst_pair_imm", 32'(o_imm), 32'h0002);

    // Randomized traffic.
    pc = 32'h100;
    for (int n = 0; n < 600; n++) begin
      w = 16'($urandom);
      if ($urandom_range(9) < 3) w[15:13] = 3'b110;
      else if (w[15:13] == 3'b110) w[13] = 1'b1;
      step($urandom_range(3) != 0, w, pc, $urandom_range(3) == 0,
           $urandom_range(19) == 0, $urandom_range(99) == 0, $urandom_range(7) == 0);
      pc = pc + 32'd1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Pipeline register between the fetch stage and decode, consuming the 16-bit words fetch emits each cycle. It assembles two-word (immediate-bearing) instructions and presents complete instructions to decode with a valid flag. It also backpressures fetch so the PC freezes while decode stalls, and drops in-flight words on a branch flush. Optionally, it injects an interrupt pseudo-instruction at an instruction boundary.

## Interface
- (no parameters; widths fixed by ISA: 16-bit words, 32-bit PC)
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_word  in  16  instruction word from fetch
- i_pc  in  32  address of i_word
- i_valid  in  1  i_word is valid this cycle
- o_ready  out  1  word accepted this cycle; fetch advances PC only when high
- i_stall  in  1  decode cannot take a new instruction
- i_flush  in  1  discard everything in flight (taken branch/jump)
- i_interrupt  in  1  interrupt request level (used only with INTERRUPT_EN)
- o_valid  out  1  o_instr/o_imm/o_pc hold a complete instruction
- o_instr  out  16  first (opcode) word
- o_imm  out  16  immediate word; 0 when o_has_imm=0
- o_has_imm  out  1  instruction is two-word
- o_pc  out  32  address of first word
- o_is_int  out  1  output is injected interrupt pseudo-instruction

## Operation
- Two-word rule: i_word[15:13] == IMM_PREFIX (3'b110) marks an opcode word followed by one immediate word.
- FSM states:
  - FIRST (reset state): accepting an opcode word.
  - SECOND: opcode latched, accepting the immediate.
- Accept = i_valid && o_ready. o_ready = !(o_valid && i_stall) && !inject.
- FIRST + accept:
  - Non-prefix word: load output register (o_has_imm=0, o_imm=0), o_valid=1, stay FIRST.
  - Prefix word: latch word and pc in hold register, o_valid=0 next cycle, go SECOND.
- SECOND + accept: output = {held word, i_word, held pc}, o_has_imm=1, o_valid=1, go FIRST.
- Output register updates only when not (o_valid && i_stall). If it is free and nothing completes, o_valid drops to 0.
- Priority: i_reset > i_flush > stall > accept.
- Flush: o_valid=0, hold register cleared, state=FIRST. A word presented in the flush cycle is discarded, but o_ready stays as computed so fetch is not blocked.
- Reset values:
  - All outputs 0, except o_ready=1 and o_is_int=0.
  - State FIRST, pending interrupt cleared.

## Timing
- Latency is one cycle from accepting the last word to o_valid.
- Throughput:
  - One single-word instruction per cycle.
  - One two-word instruction per two cycles.
- Stall holds all outputs bit-stable. o_ready falls combinationally in the same cycle.
- Stall in SECOND with o_valid=1: the immediate is not accepted until the stall releases.
- Reset or flush mid-pair abandons the held opcode word; nothing is emitted for it.

## Configuration
- INTERRUPT_EN defined:
  - A rising edge on i_interrupt sets a pending flag. The flag survives flush and is cleared only on injection or reset.
  - Injection happens when pending && state==FIRST && the output register is free (not o_valid&&i_stall).
  - That cycle: inject=1, o_ready=0 (no word consumed, PC holds). Next cycle: o_valid=1, o_is_int=1, o_instr=INT_OPCODE, o_pc=i_pc of the inject cycle, o_has_imm=0.
  - Requests arriving in SECOND wait until the pair completes.
- INTERRUPT_EN undefined:
  - i_interrupt is ignored; o_is_int is tied 0; inject is constant 0.

## Structure
- Shared package isa_pkg: IMM_PREFIX, INT_OPCODE, word/PC width constants, and the FIRST/SECOND state encoding.
- One sub-module is natural: int_pending_reg, which does edge detection plus the pending flag. It is instantiated only under INTERRUPT_EN.

## Test plan
- Reset, then words 0x1234@0, 0x2000@1 with valid each cycle -> o_valid on cycles 1 and 2 with o_instr 0x1234 then 0x2000, o_has_imm=0, o_ready=1 throughout.
- Word 0xC005@4 then 0x00FF@5 -> one cycle after 0x00FF, output o_instr=0xC005, o_imm=0x00FF, o_pc=4, o_has_imm=1, with o_valid low in the intermediate cycle.
- o_valid=1 and i_stall high for 3 cycles -> outputs unchanged and o_ready=0 for 3 cycles. The next word appears one cycle after the stall drops.
- Flush while in SECOND after 0xC005 -> no output for 0xC005. Next word 0x1111@20 emits normally, o_has_imm=0.
- INTERRUPT_EN: pulse i_interrupt during SECOND of 0xC005/0x0001 -> pair emitted first. Then o_ready=0 for one cycle, followed by o_is_int=1, o_instr=INT_OPCODE, o_pc=next fetch address.
- Synchronous reset asserted while o_valid=1 -> o_valid=0 on the next edge and state FIRST. A prefix word after reset is treated as an opcode word.
